// File: rtl/bs_drvr_fifo_if.sv
// bs_drvr_fifo_if: per-driver TX/RX FIFO pair sitting on one parallel-bus driver port.
// TX buffers device words for the arbiter (show-ahead); RX captures words the bus delivers.

module bs_drvr_fifo_core #(
  parameter int bits  = 256,
  parameter int depth = 16,
  parameter int cw    = $clog2(depth) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr,
  input  logic [bits-1:0] wr_data,
  input  logic            rd,
  output logic [bits-1:0] rd_data,
  output logic            not_empty,
  output logic            full,
  output logic [cw-1:0]   count,
  output logic            drop_flag
);

  localparam int aw = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [cw-1:0] depth_c = cw'(depth);
  localparam logic [aw-1:0] last_c  = aw'(depth - 1);

  logic [bits-1:0] mem [depth];
  logic [aw-1:0]   wr_ptr;
  logic [aw-1:0]   rd_ptr;
  logic [cw-1:0]   cnt;
  logic            drop;
  logic            rd_ok;
  logic            wr_ok;

  function automatic logic [aw-1:0] ptr_inc(input logic [aw-1:0] p);
    return (p == last_c) ? {aw{1'b0}} : p + aw'(1'b1);
  endfunction

  // A read needs data present; a write needs space, or a valid read freeing a slot this edge.
  always_comb begin
    rd_ok = rd && (cnt != {cw{1'b0}});
    wr_ok = wr && ((cnt != depth_c) || rd_ok);
  end

  // Storage is not reset: contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= {aw{1'b0}};
      rd_ptr <= {aw{1'b0}};
      cnt    <= {cw{1'b0}};
      drop   <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rd_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + cw'(1'b1);
        2'b01:   cnt <= cnt - cw'(1'b1);
        default: cnt <= cnt;
      endcase
      if (wr && !wr_ok) begin
        drop <= 1'b1;
      end
    end
  end

  assign not_empty = (cnt != {cw{1'b0}});
  assign full      = (cnt == depth_c);
  assign count     = cnt;
  assign drop_flag = drop;
  // Head word is forced to zero while empty so stale storage never leaks onto the bus.
  assign rd_data   = not_empty ? mem[rd_ptr] : {bits{1'b0}};

endmodule

module bs_drvr_fifo_if #(
  parameter int bits  = 256,
  parameter int depth = 16,
  parameter int cw    = $clog2(depth) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_push,
  input  logic [bits-1:0] tx_D_in,
  output logic            tx_full,
  output logic [cw-1:0]   tx_count,
  output logic            pndng,
  input  logic            pop,
  output logic [bits-1:0] D_pop,
  input  logic            push,
  input  logic [bits-1:0] D_push,
  output logic            rx_pndng,
  input  logic            rx_pop,
  output logic [bits-1:0] rx_D_out,
  output logic [cw-1:0]   rx_count,
  output logic            tx_err,
  output logic            rx_ovf
);

  logic rx_full;

  bs_drvr_fifo_core #(.bits(bits), .depth(depth), .cw(cw)) u_tx (
    .clk       (clk),
    .reset     (reset),
    .wr        (tx_push),
    .wr_data   (tx_D_in),
    .rd        (pop),
    .rd_data   (D_pop),
    .not_empty (pndng),
    .full      (tx_full),
    .count     (tx_count),
    .drop_flag (tx_err)
  );

  // RX has no backpressure toward the arbiter, so its full flag is only used internally.
  bs_drvr_fifo_core #(.bits(bits), .depth(depth), .cw(cw)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .wr        (push),
    .wr_data   (D_push),
    .rd        (rx_pop),
    .rd_data   (rx_D_out),
    .not_empty (rx_pndng),
    .full      (rx_full),
    .count     (rx_count),
    .drop_flag (rx_ovf)
  );

  logic unused_rx_full;
  assign unused_rx_full = rx_full;

endmodule

// File: tb/tb_bs_drvr_fifo_if.sv
// Self-checking bench for bs_drvr_fifo_if: vector table plus queue scoreboard, depth 4.
module tb_bs_drvr_fifo_if;

  localparam int BITS  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            tx_push;
  logic [BITS-1:0] tx_D_in;
  logic            tx_full;
  logic [CW-1:0]   tx_count;
  logic            pndng;
  logic            pop;
  logic [BITS-1:0] D_pop;
  logic            push;
  logic [BITS-1:0] D_push;
  logic            rx_pndng;
  logic            rx_pop;
  logic [BITS-1:0] rx_D_out;
  logic [CW-1:0]   rx_count;
  logic            tx_err;
  logic            rx_ovf;

  bs_drvr_fifo_if #(.bits(BITS), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .tx_push(tx_push), .tx_D_in(tx_D_in), .tx_full(tx_full), .tx_count(tx_count),
    .pndng(pndng), .pop(pop), .D_pop(D_pop),
    .push(push), .D_push(D_push), .rx_pndng(rx_pndng), .rx_pop(rx_pop),
    .rx_D_out(rx_D_out), .rx_count(rx_count), .tx_err(tx_err), .rx_ovf(rx_ovf)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [BITS-1:0] txq[$];
  logic [BITS-1:0] rxq[$];
  logic            m_tx_err = 1'b0;
  logic            m_rx_ovf = 1'b0;

  typedef struct {
    logic            tp;
    logic [BITS-1:0] td;
    logic            p;
    logic            bp;
    logic [BITS-1:0] bd;
    logic            rp;
    int              e_tx_count;
    logic            e_pndng;
    logic [BITS-1:0] e_dpop;
    int              e_rx_count;
    logic [BITS-1:0] e_rx_dout;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, score the show-ahead heads, update the model, check after the edge.
  task automatic step(input logic tp, input logic [BITS-1:0] td, input logic p,
                      input logic bp, input logic [BITS-1:0] bd, input logic rp);
    logic [BITS-1:0] e;
    tx_push = tp; tx_D_in = td; pop = p;
    push = bp; D_push = bd; rx_pop = rp;
    if (p && txq.size() > 0) begin
      e = txq.pop_front();
      chk("tx_head_on_pop", D_pop, e);
    end
    if (rp && rxq.size() > 0) begin
      e = rxq.pop_front();
      chk("rx_head_on_pop", rx_D_out, e);
    end
    if (tp) begin
      if (txq.size() < DEPTH) txq.push_back(td);
      else m_tx_err = 1'b1;
    end
    if (bp) begin
      if (rxq.size() < DEPTH) rxq.push_back(bd);
      else m_rx_ovf = 1'b1;
    end
    @(posedge clk); #1;
    chk("tx_count", BITS'(tx_count), BITS'(txq.size()));
    chk("pndng", BITS'(pndng), BITS'(txq.size() != 0));
    chk("D_pop", D_pop, (txq.size() != 0) ? txq[0] : '0);
    chk("tx_full", BITS'(tx_full), BITS'(txq.size() == DEPTH));
    chk("tx_err", BITS'(tx_err), BITS'(m_tx_err));
    chk("rx_count", BITS'(rx_count), BITS'(rxq.size()));
    chk("rx_pndng", BITS'(rx_pndng), BITS'(rxq.size() != 0));
    chk("rx_D_out", rx_D_out, (rxq.size() != 0) ? rxq[0] : '0);
    chk("rx_ovf", BITS'(rx_ovf), BITS'(m_rx_ovf));
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_pndng", BITS'(pndng), '0);
    chk("rst_tx_count", BITS'(tx_count), '0);
    chk("rst_D_pop", D_pop, '0);
    chk("rst_rx_pndng", BITS'(rx_pndng), '0);
    chk("rst_rx_count", BITS'(rx_count), '0);
    chk("rst_rx_D_out", rx_D_out, '0);
    chk("rst_tx_full", BITS'(tx_full), '0);
    chk("rst_flags", BITS'({tx_err, rx_ovf}), '0);
    txq.delete(); rxq.delete();
    m_tx_err = 1'b0; m_rx_ovf = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    tx_push = 1'b0; tx_D_in = '0; pop = 1'b0;
    push = 1'b0; D_push = '0; rx_pop = 1'b0;

    vecs[0] = '{1'b1, 32'hA1, 1'b0, 1'b1, 32'hB0, 1'b1, 1, 1'b1, 32'hA1, 1, 32'hB0};
    vecs[1] = '{1'b1, 32'hA2, 1'b0, 1'b0, 32'h0,  1'b1, 2, 1'b1, 32'hA1, 0, 32'h0};
    vecs[2] = '{1'b1, 32'hA3, 1'b0, 1'b0, 32'h0,  1'b0, 3, 1'b1, 32'hA1, 0, 32'h0};
    vecs[3] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b1, 2, 1'b1, 32'hA2, 0, 32'h0};
    vecs[4] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 1, 1'b1, 32'hA3, 0, 32'h0};
    vecs[5] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 0, 1'b0, 32'h0,  0, 32'h0};

    @(posedge clk); #1;
    do_reset();

    // Reset while TX holds 3 words, then a pop after release must be ignored.
    step(1'b1, 32'h11, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 32'h12, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 32'h13, 1'b0, 1'b0, '0, 1'b0);
    chk("pre_reset_count", BITS'(tx_count), 32'd3);
    do_reset();
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    chk("pop_after_reset", BITS'(tx_count), 32'd0);

    // TX ordering plus empty simultaneous RX push/pop.
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].tp, vecs[i].td, vecs[i].p, vecs[i].bp, vecs[i].bd, vecs[i].rp);
      chk($sformatf("vec%0d_tx_count", i), BITS'(tx_count), BITS'(vecs[i].e_tx_count));
      chk($sformatf("vec%0d_pndng", i), BITS'(pndng), BITS'(vecs[i].e_pndng));
      chk($sformatf("vec%0d_D_pop", i), D_pop, vecs[i].e_dpop);
      chk($sformatf("vec%0d_rx_count", i), BITS'(rx_count), BITS'(vecs[i].e_rx_count));
      chk($sformatf("vec%0d_rx_D_out", i), rx_D_out, vecs[i].e_rx_dout);
    end
    idle();

    // TX full: 5 pushes without pop, fifth dropped.
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, BITS'(i), 1'b0, 1'b0, '0, 1'b0);
      if (i == 4) chk("tx_full_after_4", BITS'(tx_full), 32'd1);
    end
    chk("tx_err_after_5", BITS'(tx_err), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("tx_drain_head", D_pop, BITS'(i));
      step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    end
    chk("tx_drained", BITS'(pndng), 32'd0);
    chk("tx_err_sticky", BITS'(tx_err), 32'd1);
    do_reset();

    // Full with simultaneous push+pop, then drain across the pointer wrap.
    for (int i = 1; i <= 4; i++) step(1'b1, BITS'(i), 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 32'h9, 1'b1, 1'b0, '0, 1'b0);
    chk("full_pp_count", BITS'(tx_count), 32'd4);
    chk("full_pp_err", BITS'(tx_err), 32'd0);
    chk("full_pp_head", D_pop, 32'h2);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("wrap_empty", BITS'(tx_count), 32'd0);

    // RX overflow and pop-while-empty.
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b1, 32'hFF00 + BITS'(i), 1'b0);
    chk("rx_ovf_set", BITS'(rx_ovf), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("rx_drain_head", rx_D_out, 32'hFF00 + BITS'(i));
      step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    end
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    chk("rx_pop_empty", BITS'(rx_count), 32'd0);
    chk("rx_ovf_sticky", BITS'(rx_ovf), 32'd1);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bs_drvr_fifo_if.md
Name: bs_drvr_fifo_if

Overview:
Per-driver FIFO interface that sits directly on one driver port of the parallel bus generator/arbiter.
- TX side: buffers words the local device wants to send. It presents them to the bus as pndng/D_pop, show-ahead, and the arbiter consumes them with pop.
- RX side: captures words the bus delivers via push/D_push and buffers them until the local device reads them.
- One instance per driver per bus; two instances serve the 2-driver wrapper.

Parameters:
- bits, 256, word width; must equal the bus arbiter's bits. Bits [bits-1:bits-8] carry the destination ID, passed through untouched.
- depth, 16, entries per FIFO (TX and RX each); power of 2, minimum 2.
- cw, $clog2(depth)+1, occupancy count width (derived; do not override).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high.
- tx_push  input  1  device writes tx_D_in into TX FIFO.
- tx_D_in  input  bits  TX write data.
- tx_full  output  1  TX FIFO holds depth words.
- tx_count  output  cw  TX occupancy.
- pndng  output  1  TX FIFO non-empty; to arbiter pndng.
- pop  input  1  arbiter consumes head word.
- D_pop  output  bits  TX head word; to arbiter D_pop.
- push  input  1  arbiter delivers D_push.
- D_push  input  bits  RX write data from bus.
- rx_pndng  output  1  RX FIFO non-empty.
- rx_pop  input  1  device consumes RX head word.
- rx_D_out  output  bits  RX head word, show-ahead.
- rx_count  output  cw  RX occupancy.
- tx_err  output  1  sticky: tx_push attempted while full with no pop.
- rx_ovf  output  1  sticky: bus push dropped because RX full with no rx_pop.

Behaviour:
- Reset (asynchronous, any time):
  - All pointers and counts go to 0.
  - pndng=0, rx_pndng=0, tx_full=0, tx_err=0, rx_ovf=0, D_pop=0, rx_D_out=0.
  - Storage contents are don't-care; any in-flight data is discarded.
- Both FIFOs are circular buffers with wr_ptr/rd_ptr wrapping at depth-1 -> 0, plus a count register. full = (count==depth). empty = (count==0).
- Show-ahead read:
  - D_pop equals mem[rd_ptr] whenever pndng=1; D_pop=0 when empty. rx_D_out behaves the same way.
  - A word written into an empty FIFO at edge N is visible on D_pop/pndng after edge N (one-cycle write-to-read latency).
  - No fall-through in the same cycle.
- pop is honoured only when pndng=1. A pop while empty is ignored and does not change state. rx_pop follows the same rule with rx_pndng.
- Each pop/rx_pop high for one cycle removes exactly one word at that edge. The next word is visible after the edge, so back-to-back pops drain one word per cycle.
- TX write: tx_push accepted if not full, or if full and pop is valid in the same cycle (count unchanged, both pointers advance).
  - Otherwise the word is discarded, tx_err is set, and stays set until reset.
- RX write: push accepted if not full, or if full with rx_pop in the same cycle.
  - Otherwise D_push is dropped and rx_ovf is set (sticky).
  - The arbiter has no backpressure, so a drop is the only possible outcome.
- Simultaneous write and read on a non-empty FIFO: count unchanged.
- Simultaneous write and read on an empty FIFO: the read is ignored, the write is stored, count becomes 1.
- Count arithmetic: +1 on write only, -1 on read only, 0 on both. Counts never exceed depth and never underflow.
- Data ordering is strict FIFO; the ID field is not inspected.
- TX and RX paths are fully independent. No combinational path from pop to pndng, or from push to rx_pndng.

Test Plan:
- Reset/idle: assert reset mid-run with TX holding 3 words -> pndng=0, tx_count=0, D_pop=0 immediately (asynchronous). After release, a pop is ignored.
- TX ordering: depth=4; push 0xA1, 0xA2, 0xA3 on consecutive cycles, then pop 3 cycles back-to-back -> D_pop shows A1, A2, A3; pndng falls after the third pop; tx_count goes 1, 2, 3, 2, 1, 0.
- TX full/error: push 5 words 0x1..0x5 with no pop -> tx_full=1 after the 4th; the 5th is dropped and tx_err=1. Pops return 0x1..0x4 only.
- Full with simultaneous push+pop: TX full with 0x1..0x4; push 0x9 with pop in the same cycle -> tx_count stays 4, tx_err=0. Subsequent pops return 0x2, 0x3, 0x4, 0x9 (checks pointer wrap).
- RX overflow: 5 bus pushes with D_push=0xFF00..04 into depth-4 RX, no rx_pop -> rx_ovf=1; rx_D_out returns words ..00 through ..03. An rx_pop while empty leaves rx_count=0.
- Empty simultaneous: RX empty, push 0xB0 with rx_pop in the same cycle -> rx_count=1, rx_pndng=1 next cycle, rx_D_out=0xB0.
